tone_phase_sequencer: RTL
=========================

Name: tone_phase_sequencer

Overview:
- Time-multiplexed per-voice phase accumulator; the stage directly upstream and downstream of the 256x24 tone-constant ROM.
- On each sample tick it walks all voices in order. For each voice it drives the ROM address with the voice's note index, takes back the 24-bit phase increment, and adds it to that voice's phase register.
- Emits one phase word per voice per frame to the oscillator/waveform stage.

Parameters:
- VOICES, 8, number of voices; power of 2, at least 2.
- PHASE_W, 32, phase accumulator width.
- INC_W, 24, tone-constant (ROM data) width; INC_W ≤ PHASE_W.
- ADDR_W, 8, ROM address / note index width.
- VW, $clog2(VOICES), voice index width (derived, localparam).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- sample_tick  in  1  one-cycle pulse; starts a frame.
- note_we  in  1  note/gate register write strobe.
- note_wr_voice  in  VW  voice being written.
- note_wr_note  in  ADDR_W  note index (ROM address) for that voice.
- note_wr_gate  in  1  gate for that voice (1 = sounding).
- rom_addr  out  ADDR_W  registered address to the tone ROM.
- rom_q  in  INC_W  ROM data; valid one clock after rom_addr is sampled.
- phase_out  out  PHASE_W  updated phase of voice_out.
- voice_out  out  VW  voice index of phase_out.
- phase_valid  out  1  one-cycle strobe qualifying phase_out and voice_out.
- frame_done  out  1  one-cycle pulse after the last voice.
- busy  out  1  high from FETCH of voice 0 through DONE.
- overrun  out  1  sticky; set when a tick arrives while busy.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset state while reset_n = 0 at a clk edge:
  - all outputs 0;
  - state IDLE, voice counter 0;
  - all note registers 0, all gates 0, all phases 0;
  - overrun cleared.
- Reset mid-frame aborts the frame. No further phase_valid or frame_done until the next tick.
- Note register file:
  - Writes take effect at the clk edge where note_we = 1.
  - Writes are accepted in any state.
  - FETCH samples the note register at its own edge. A write to the same voice in the same cycle as that FETCH is used from the next frame onward.
- FSM states: IDLE, FETCH, WAIT, ACC, DONE.
  - IDLE: on sample_tick, voice counter set to 0, go to FETCH.
  - FETCH: rom_addr ← note[v], go to WAIT.
  - WAIT: the ROM registers rom_q this edge; go to ACC.
  - ACC:
    - If gate[v] = 1: phase[v] ← (phase[v] + zero-extended rom_q) mod 2^PHASE_W.
    - If gate[v] = 0: phase[v] is held.
    - In both cases: phase_out ← new phase[v], voice_out ← v, phase_valid ← 1.
    - If v = VOICES-1, go to DONE; otherwise v ← v+1 and go to FETCH.
  - DONE: frame_done ← 1 for one cycle, go to IDLE.
- Latency and throughput:
  - 3 cycles per voice.
  - Voice v's phase_valid is high in cycle 3+3v after the edge that samples the tick.
  - frame_done is high in cycle 3·VOICES+1.
  - Minimum tick spacing is 3·VOICES+2 cycles.
- Ticks arriving in any state other than IDLE (including DONE) are ignored and set overrun. overrun clears only on reset.
- rom_addr holds its last value outside FETCH.
- Wrap-around: the accumulator wraps silently modulo 2^PHASE_W; there is no saturation.

Optional Feature:
- Macro: PHASE_RESET_ON_KEY_EN.
- Defined:
  - A gate write changing gate[v] from 0 to 1 sets a per-voice pending flag.
  - At that voice's next ACC: phase[v] ← zero-extended rom_q, i.e. accumulation restarts from 0. The flag then clears.
  - A gate 0→1 write landing in the same cycle as that voice's ACC is deferred to the next frame.
- Not defined:
  - There are no pending flags; phases run free across key-on.
  - Gate only selects accumulate or hold.

Test Plan:
- Reset values: hold reset_n = 0 for 2 cycles, release → all outputs 0. Then one tick with all gates 0 → 8 phase_valid strobes 3 cycles apart, all phase_out = 0, voice_out 0..7, frame_done in cycle 25.
- Single voice: ROM model rom[0x05] = 0x000100; write voice 2 note = 0x05, gate = 1; issue 3 ticks 30 cycles apart → voice 2 phase_out = 0x100, 0x200, 0x300, and rom_addr = 0x05 during voice 2's WAIT.
- Wrap: preload voice 0 to 0xFFFFFF80 via repeated ticks with rom[0x01] = 0xFFFFFF; next step with increment 0x000100 → phase_out = 0x00000080.
- Overrun: issue a tick, then a second tick 10 cycles later → second tick ignored, overrun = 1 and stays 1, frame completes normally with 8 strobes.
- Reset mid-frame: assert reset_n = 0 during voice 4's WAIT → no strobes for voices 4..7, no frame_done, all phases 0 on the next frame.
- Key-on, with PHASE_RESET_ON_KEY_EN: voice 1 accumulates to 0x500. Then write gate 0 and run 1 frame; phase_out stays 0x500. Then write gate 1 with rom[note] = 0x100 → next phase_out = 0x100. Without the macro the same sequence gives 0x600.

Source files
------------

// File: rtl/tone_phase_sequencer.sv
// Time-multiplexed per-voice phase accumulator around the 256x24 tone-constant ROM.
// Optional key-on phase restart is compiled in with PHASE_RESET_ON_KEY_EN.
module tone_phase_sequencer #(
  parameter int VOICES  = 8,
  parameter int PHASE_W = 32,
  parameter int INC_W   = 24,
  parameter int ADDR_W  = 8,
  localparam int VW     = $clog2(VOICES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_tick,
  input  logic               note_we,
  input  logic [VW-1:0]      note_wr_voice,
  input  logic [ADDR_W-1:0]  note_wr_note,
  input  logic               note_wr_gate,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INC_W-1:0]   rom_q,
  output logic [PHASE_W-1:0] phase_out,
  output logic [VW-1:0]      voice_out,
  output logic               phase_valid,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun
);

  // state | meaning
  // IDLE  | waiting for sample_tick
  // FETCH | present note[v] as ROM address
  // WAIT  | ROM registers its data
  // ACC   | update phase[v], emit strobe
  // DONE  | frame_done pulse, back to IDLE
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ACC, DONE} state_t;

  state_t              state;
  logic [VW-1:0]       v;
  logic [ADDR_W-1:0]   note [VOICES];
  logic [VOICES-1:0]   gate;
  logic [PHASE_W-1:0]  phase [VOICES];
  logic [PHASE_W-1:0]  inc;
  logic [PHASE_W-1:0]  acc_next;
`ifdef PHASE_RESET_ON_KEY_EN
  logic [VOICES-1:0]   pending;
`endif

  assign inc = PHASE_W'(rom_q);

  always_comb begin
    acc_next = phase[v];
    if (gate[v]) acc_next = phase[v] + inc;
`ifdef PHASE_RESET_ON_KEY_EN
    if (gate[v] && pending[v]) acc_next = inc;
`endif
  end

  // Note/gate register file; a key-on landing on the voice's own ACC edge wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < VOICES; i++) note[i] <= '0;
      gate <= '0;
`ifdef PHASE_RESET_ON_KEY_EN
      pending <= '0;
`endif
    end else begin
`ifdef PHASE_RESET_ON_KEY_EN
      if (state == ACC) pending[v] <= 1'b0;
      if (note_we && note_wr_gate && !gate[note_wr_voice]) pending[note_wr_voice] <= 1'b1;
`endif
      if (note_we) begin
        note[note_wr_voice] <= note_wr_note;
        gate[note_wr_voice] <= note_wr_gate;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      v           <= '0;
      rom_addr    <= '0;
      phase_out   <= '0;
      voice_out   <= '0;
      phase_valid <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < VOICES; i++) phase[i] <= '0;
    end else begin
      phase_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            v     <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          rom_addr <= note[v];
          state    <= WAIT;
        end
        WAIT: state <= ACC;
        ACC: begin
          phase[v]    <= acc_next;
          phase_out   <= acc_next;
          voice_out   <= v;
          phase_valid <= 1'b1;
          if (v == VW'(VOICES - 1)) begin
            state <= DONE;
          end else begin
            v     <= v + VW'(1);
            state <= FETCH;
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
